// File: rtl/sram_like_pkg.sv
// Shared encodings for the sram-like arbiter: access sizes and arbiter FSM states.
package sram_like_pkg;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  typedef enum logic {
    ST_IDLE,
    ST_LOCKED
  } arb_state_e;

endpackage

// File: rtl/owner_fifo.sv
// Synchronous FIFO holding the owning channel of each accepted, unanswered request.
// Pointers carry one extra wrap bit so full and empty are distinguishable.
module owner_fifo #(
  parameter int unsigned Width = 1,
  parameter int unsigned Depth = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     push_i,
  input  logic [Width-1:0]         data_i,
  input  logic                     pop_i,
  output logic [Width-1:0]         data_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(Depth):0]   count_o
);

  localparam int unsigned PW = $clog2(Depth);

  logic [Width-1:0] mem_q [Depth];
  logic [PW:0]      wr_ptr_q, rd_ptr_q;
  logic             do_push, do_pop;

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[PW] != rd_ptr_q[PW]) && (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);
  assign count_o = wr_ptr_q - rd_ptr_q;
  assign data_o  = mem_q[rd_ptr_q[PW-1:0]];
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int i = 0; i < int'(Depth); i++) mem_q[i] <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q[PW-1:0]] <= data_i;
        wr_ptr_q                <= wr_ptr_q + (PW+1)'(1);
      end
      if (do_pop) rd_ptr_q <= rd_ptr_q + (PW+1)'(1);
    end
  end

endmodule

// File: rtl/sram_like_arbiter.sv
// Arbitrates NCH sram-like master channels onto one slave bus, routing in-order responses back
// to their owners. Define SRAM_LIKE_ARB_RR_EN for round-robin instead of fixed priority.
module sram_like_arbiter
  import sram_like_pkg::*;
#(
  parameter int unsigned NCH     = 2,
  parameter int unsigned AW      = 32,
  parameter int unsigned DW      = 32,
  parameter int unsigned MAX_OUT = 4
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic [NCH-1:0]             m_req,
  input  logic [NCH-1:0]             m_wr,
  input  logic [2*NCH-1:0]           m_size,
  input  logic [AW*NCH-1:0]          m_addr,
  input  logic [DW*NCH-1:0]          m_wdata,
  output logic [NCH-1:0]             m_addr_ok,
  output logic [NCH-1:0]             m_data_ok,
  output logic [DW-1:0]              m_rdata,
  output logic                       s_req,
  output logic                       s_wr,
  output logic [1:0]                 s_size,
  output logic [AW-1:0]              s_addr,
  output logic [DW-1:0]              s_wdata,
  input  logic                       s_addr_ok,
  input  logic                       s_data_ok,
  input  logic [DW-1:0]              s_rdata,
  output logic [$clog2(MAX_OUT):0]   outstanding,
  output logic                       err
);

  localparam int unsigned IW = (NCH > 1) ? $clog2(NCH) : 1;

  arb_state_e     state_q, state_d;
  logic [IW-1:0]  grant_q, grant_d;
  logic           err_q, err_d;
  logic [DW-1:0]  rdata_q, rdata_d;
  logic [IW-1:0]  winner, cur_ch, head;
  logic           sel_valid, full, empty, accept, pop;

`ifdef SRAM_LIKE_ARB_RR_EN
  logic [IW-1:0]  rr_q, rr_d;

  // Scan from the pointer upwards; the smallest offset is assigned last and wins.
  always_comb begin
    int idx;
    idx    = 0;
    winner = '0;
    for (int k = int'(NCH) - 1; k >= 0; k--) begin
      idx = int'(rr_q) + k;
      if (idx >= int'(NCH)) idx = idx - int'(NCH);
      if (m_req[idx]) winner = IW'(idx);
    end
  end

  always_comb begin
    int nxt;
    nxt  = int'(cur_ch) + 1;
    rr_d = rr_q;
    if (accept) rr_d = (nxt >= int'(NCH)) ? '0 : IW'(nxt);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) rr_q <= '0;
    else         rr_q <= rr_d;
  end
`else
  always_comb begin
    winner = '0;
    for (int i = 0; i < int'(NCH); i++) begin
      if (m_req[i]) winner = IW'(i);
    end
  end
`endif

  // A locked grant keeps the downstream request stable until it is accepted.
  assign cur_ch    = (state_q == ST_LOCKED) ? grant_q : winner;
  assign sel_valid = (state_q == ST_LOCKED) ? m_req[grant_q] : |m_req;
  assign s_req     = resetn && !full && sel_valid;
  assign accept    = s_req && s_addr_ok;
  assign pop       = s_data_ok && !empty;
  assign err       = err_q;

  owner_fifo #(
    .Width (IW),
    .Depth (MAX_OUT)
  ) u_owner_fifo (
    .clk_i   (clk),
    .rst_ni  (resetn),
    .push_i  (accept),
    .data_i  (cur_ch),
    .pop_i   (pop),
    .data_o  (head),
    .full_o  (full),
    .empty_o (empty),
    .count_o (outstanding)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= ST_IDLE;
      grant_q <= '0;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    err_d   = err_q;
    rdata_d = pop ? s_rdata : rdata_q;
    if (s_data_ok && empty) err_d = 1'b1;
    unique case (state_q)
      ST_IDLE: begin
        if (s_req && !s_addr_ok) begin
          state_d = ST_LOCKED;
          grant_d = winner;
        end
      end
      ST_LOCKED: begin
        if (!m_req[grant_q]) begin
          err_d   = 1'b1;
          state_d = ST_IDLE;
        end else if (s_addr_ok) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    m_addr_ok = '0;
    m_data_ok = '0;
    s_wr      = 1'b0;
    s_size    = SZ_BYTE;
    s_addr    = '0;
    s_wdata   = '0;
    if (accept) m_addr_ok[cur_ch] = 1'b1;
    if (pop)    m_data_ok[head]   = 1'b1;
    m_rdata = pop ? s_rdata : rdata_q;
    for (int i = 0; i < int'(NCH); i++) begin
      if (cur_ch == IW'(i)) begin
        s_wr    = m_wr[i];
        s_size  = m_size[2*i +: 2];
        s_addr  = m_addr[AW*i +: AW];
        s_wdata = m_wdata[DW*i +: DW];
      end
    end
  end

endmodule
